urv_mtimer: RTL and testbench

URV_MTIMER -- requirements
Module: urv_mtimer

---
 rtl/urv_defs.sv | 19 +
 rtl/urv_timer_cmp.sv | 60 ++++++
 rtl/urv_mtimer.sv | 113 +++++++++++
 tb/tb_urv_mtimer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/urv_defs.sv
// Shared register map and CTRL bit layout for the uRV machine timer.
// Period registers only exist when URV_TIMER_PERIODIC_EN is defined.
package urv_defs;

    localparam int unsigned ADDR_TIME     = 0;
    localparam int unsigned ADDR_CTRL     = 1;
    localparam int unsigned ADDR_CMP_BASE = 2;

    localparam int unsigned CTRL_EN_BIT = 0;

    localparam int unsigned MAX_CMP          = 14;
    localparam int unsigned MAX_CMP_PERIODIC = 7;

    // Period registers sit directly after the last compare register.
    function automatic int unsigned addr_period_base(input int unsigned num_cmp);
        return ADDR_CMP_BASE + num_cmp;
    endfunction

endpackage

// File: rtl/urv_timer_cmp.sv
// One compare channel: CMP register, IRQ level/pulse, and (with
// URV_TIMER_PERIODIC_EN) a period register that auto-advances CMP on a match.
module urv_timer_cmp #(
    parameter int unsigned g_width = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmp_wr_i,
`ifdef URV_TIMER_PERIODIC_EN
    input  logic               per_wr_i,
`endif
    input  logic [g_width-1:0] data_i,
    input  logic [g_width-1:0] time_i,
    output logic               irq_o
);

    logic [g_width-1:0] cmp_q;
    logic               hit;
    logic               irq_q;

    always_comb begin
        hit = (time_i >= cmp_q);
    end

`ifdef URV_TIMER_PERIODIC_EN
    logic [g_width-1:0] per_q;

    // Advancing CMP on the match edge makes the next compare fail, so the IRQ
    // becomes a single-cycle pulse; a zero period leaves CMP alone (level mode).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cmp_q <= '1;
            per_q <= '0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= hit;
            if (cmp_wr_i)
                cmp_q <= data_i;
            else if (hit && (per_q != '0))
                cmp_q <= cmp_q + per_q;
            if (per_wr_i)
                per_q <= data_i;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            irq_q <= hit;
            if (cmp_wr_i)
                cmp_q <= data_i;
        end
    end
`endif

    assign irq_o = irq_q;

endmodule

// File: rtl/urv_mtimer.sv
// Machine timer: prescaled tick counter, free-running cycle counter and
// g_num_cmp compare channels. Optional feature macro: URV_TIMER_PERIODIC_EN.
module urv_mtimer
    import urv_defs::*;
#(
    parameter int unsigned g_clock_frequency = 62500000,
    parameter int unsigned g_timer_frequency = 1000,
    parameter int unsigned g_width           = 64,
    parameter int unsigned g_num_cmp         = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_wr_i,
    input  logic [3:0]           cfg_addr_i,
    input  logic [g_width-1:0]   cfg_data_i,
    output logic [g_width-1:0]   csr_time_o,
    output logic [g_width-1:0]   csr_cycles_o,
    output logic                 sys_tick_o,
    output logic [g_num_cmp-1:0] cmp_irq_o
);

    localparam longint PRESC_MAX = longint'(g_clock_frequency / g_timer_frequency) - 1;
    localparam logic [31:0] PRESC_TERM = 32'(PRESC_MAX);

`ifdef URV_TIMER_PERIODIC_EN
    localparam int unsigned CMP_LIMIT = MAX_CMP_PERIODIC;
`else
    localparam int unsigned CMP_LIMIT = MAX_CMP;
`endif

    if (PRESC_MAX < 1) begin : g_bad_presc
        $error("urv_mtimer: clock/timer frequency ratio must be at least 2");
    end
    if (g_width < 32 || g_width > 64) begin : g_bad_width
        $error("urv_mtimer: g_width must be in 32..64");
    end
    if (g_num_cmp < 1 || g_num_cmp > CMP_LIMIT) begin : g_bad_num_cmp
        $error("urv_mtimer: g_num_cmp out of range");
    end

    logic [31:0]          presc_q;
    logic                 tick_q;
    logic                 enable_q;
    logic [g_width-1:0]   time_q;
    logic [g_width-1:0]   cycles_q;

    logic                 wr_time;
    logic                 wr_ctrl;
    logic [g_num_cmp-1:0] wr_cmp;
`ifdef URV_TIMER_PERIODIC_EN
    logic [g_num_cmp-1:0] wr_per;
`endif

    always_comb begin
        wr_time = cfg_wr_i && (cfg_addr_i == 4'(ADDR_TIME));
        wr_ctrl = cfg_wr_i && (cfg_addr_i == 4'(ADDR_CTRL));
        wr_cmp  = '0;
`ifdef URV_TIMER_PERIODIC_EN
        wr_per  = '0;
`endif
        for (int unsigned n = 0; n < g_num_cmp; n++) begin
            wr_cmp[n] = cfg_wr_i && (cfg_addr_i == 4'(ADDR_CMP_BASE + n));
`ifdef URV_TIMER_PERIODIC_EN
            wr_per[n] = cfg_wr_i && (cfg_addr_i == 4'(addr_period_base(g_num_cmp) + n));
`endif
        end
    end

    // A TIME write wins over the tick increment; the prescaler keeps running.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            enable_q <= 1'b1;
            time_q   <= '0;
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 1'b1;
            if (enable_q)
                presc_q <= (presc_q == PRESC_TERM) ? '0 : presc_q + 32'd1;
            else
                presc_q <= '0;
            tick_q <= enable_q && (presc_q == PRESC_TERM);
            if (wr_time)
                time_q <= cfg_data_i;
            else if (tick_q)
                time_q <= time_q + 1'b1;
            if (wr_ctrl)
                enable_q <= cfg_data_i[CTRL_EN_BIT];
        end
    end

    for (genvar g = 0; g < g_num_cmp; g++) begin : g_cmp
        urv_timer_cmp #(
            .g_width(g_width)
        ) u_cmp (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .cmp_wr_i (wr_cmp[g]),
`ifdef URV_TIMER_PERIODIC_EN
            .per_wr_i (wr_per[g]),
`endif
            .data_i   (cfg_data_i),
            .time_i   (time_q),
            .irq_o    (cmp_irq_o[g])
        );
    end

    assign csr_time_o   = time_q;
    assign csr_cycles_o = cycles_q;
    assign sys_tick_o   = tick_q;

endmodule

// File: tb/tb_urv_mtimer.sv
// Scoreboard bench for urv_mtimer (P=9): directed writes queue cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_urv_mtimer;

    localparam int unsigned W = 64;
    localparam int unsigned NC = 2;
    localparam int K_TIME = 0, K_CYC = 1, K_TICK = 2, K_IRQ = 3;
    localparam logic [63:0] ONES = '1;

    logic          clk;
    logic          rst_i;
    logic          cfg_wr_i;
    logic [3:0]    cfg_addr_i;
    logic [W-1:0]  cfg_data_i;
    logic [W-1:0]  csr_time_o;
    logic [W-1:0]  csr_cycles_o;
    logic          sys_tick_o;
    logic [NC-1:0] cmp_irq_o;

    urv_mtimer #(
        .g_clock_frequency(10),
        .g_timer_frequency(1),
        .g_width(W),
        .g_num_cmp(NC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .csr_time_o   (csr_time_o),
        .csr_cycles_o (csr_cycles_o),
        .sys_tick_o   (sys_tick_o),
        .cmp_irq_o    (cmp_irq_o)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_TIME:  return "time";
            K_CYC:   return "cycles";
            K_TICK:  return "sys_tick";
            default: return "cmp_irq";
        endcase
    endfunction

    // Sorted insert so phases may queue expectations in any order.
    task automatic expect_at(input int e, input int kind, input logic [63:0] val);
        exp_t it;
        int   i;
        it.cyc  = base + e;
        it.kind = kind;
        it.val  = val;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > it.cyc) i--;
        sb.insert(i, it);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_e(input int e);
        if (base + e > cyc) step(base + e - cyc);
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d);
        cfg_wr_i   = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        step(1);
        cfg_wr_i   = 1'b0;
    endtask

    initial begin : monitor
        exp_t        it;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                it = sb.pop_front();
                case (it.kind)
                    K_TIME:  act = csr_time_o;
                    K_CYC:   act = csr_cycles_o;
                    K_TICK:  act = 64'(sys_tick_o);
                    default: act = 64'(cmp_irq_o);
                endcase
                n_checks++;
                if (act !== it.val || it.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL %s at cycle %0d (due %0d): actual %0h required %0h",
                             kname(it.kind), cyc, it.cyc, act, it.val);
                end
            end
        end
    end

    initial begin
        rst_i      = 1'b0;
        cfg_wr_i   = 1'b0;
        cfg_addr_i = '0;
        cfg_data_i = '0;
        step(2);
        base = cyc;
        expect_at(0, K_TIME, 64'd0);
        expect_at(0, K_CYC, 64'd0);
        expect_at(0, K_TICK, 64'd0);
        expect_at(0, K_IRQ, 64'd0);
        rst_i = 1'b1;

        // Idle run: ticks every 10 cycles, time follows one cycle later
        for (int e = 1; e <= 35; e++) expect_at(e, K_TICK, (e % 10 == 0) ? 64'd1 : 64'd0);
        expect_at(11, K_TIME, 64'd1);
        expect_at(35, K_TIME, 64'd3);
        expect_at(35, K_CYC, 64'd35);
        goto_e(35);

        // CMP[0]=5 level IRQ, then CMP[0]=100 clears it
        expect_at(51, K_TIME, 64'd5);
        expect_at(51, K_IRQ, 64'b00);
        expect_at(52, K_IRQ, 64'b01);
        expect_at(56, K_IRQ, 64'b01);
        expect_at(57, K_IRQ, 64'b00);
        wr(4'd2, 64'd5);
        goto_e(55);
        wr(4'd2, 64'd100);

        // TIME=all-ones wraps on the next tick; both IRQs clear after the wrap
        expect_at(62, K_TIME, ONES);
        expect_at(62, K_IRQ, 64'b00);
        expect_at(63, K_IRQ, 64'b11);
        expect_at(70, K_TIME, ONES);
        expect_at(71, K_TIME, 64'd0);
        expect_at(71, K_IRQ, 64'b11);
        expect_at(72, K_IRQ, 64'b00);
        goto_e(61);
        wr(4'd0, ONES);

        // Disable for 50 cycles, re-enable, unmapped write, TIME write on a tick
        for (int e = 71; e <= 132; e++) expect_at(e, K_TICK, 64'd0);
        expect_at(73, K_CYC, 64'd73);
        expect_at(122, K_TIME, 64'd0);
        expect_at(123, K_CYC, 64'd123);
        expect_at(125, K_IRQ, 64'b00);
        expect_at(133, K_TICK, 64'd1);
        expect_at(133, K_TIME, 64'd0);
        expect_at(134, K_TIME, 64'd1000);
        expect_at(134, K_IRQ, 64'b00);
        expect_at(135, K_TIME, 64'd1000);
        expect_at(135, K_IRQ, 64'b01);
        expect_at(143, K_TICK, 64'd1);
        expect_at(143, K_TIME, 64'd1000);
        expect_at(144, K_TIME, 64'd1001);
        expect_at(147, K_IRQ, 64'b01);
        goto_e(72);
        wr(4'd1, 64'd0);
        goto_e(122);
        wr(4'd1, 64'd1);
        wr(4'd15, 64'd0);
        goto_e(133);
        wr(4'd0, 64'd1000);

        // Mid-count reset overriding a simultaneous TIME write
        expect_at(148, K_TIME, 64'd0);
        expect_at(148, K_CYC, 64'd0);
        expect_at(148, K_TICK, 64'd0);
        expect_at(148, K_IRQ, 64'b00);
        goto_e(147);
        rst_i      = 1'b0;
        cfg_wr_i   = 1'b1;
        cfg_addr_i = 4'd0;
        cfg_data_i = 64'd5;
        step(1);
        rst_i    = 1'b1;
        cfg_wr_i = 1'b0;
        base = cyc;
        expect_at(9, K_TICK, 64'd0);
        expect_at(10, K_TICK, 64'd1);
        expect_at(10, K_CYC, 64'd10);

        // CMP[0]=3 with period 4: pulses when periodic, level otherwise
        expect_at(31, K_TIME, 64'd3);
        expect_at(31, K_IRQ, 64'b00);
        expect_at(32, K_IRQ, 64'b01);
`ifdef URV_TIMER_PERIODIC_EN
        expect_at(33, K_IRQ, 64'b00);
        expect_at(71, K_IRQ, 64'b00);
        expect_at(72, K_IRQ, 64'b01);
        expect_at(73, K_IRQ, 64'b00);
        expect_at(112, K_IRQ, 64'b01);
        expect_at(113, K_IRQ, 64'b00);
`else
        expect_at(33, K_IRQ, 64'b01);
        expect_at(72, K_IRQ, 64'b01);
        expect_at(113, K_IRQ, 64'b01);
`endif
        wr(4'd2, 64'd3);
        wr(4'd4, 64'd4);
        goto_e(115);

        for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
